// File: rtl/reg_bus_arbiter.sv
// Round-robin arbiter sharing one register-file port between two requesters with one-deep pending slots.
// Write: ack 3 cycles after strobe; read: ack 4 cycles after strobe; a strobe into a full slot is dropped.
module reg_bus_arbiter #(
    parameter int ADDR_W   = 6,
    parameter int DATA_W   = 8,
    parameter int NUM_REGS = 36
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              strb0,
    input  logic              strb1,
    input  logic              we0,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata0,
    input  logic [DATA_W-1:0] wdata1,
    output logic              busy0,
    output logic              busy1,
    output logic              ack0,
    output logic              ack1,
    output logic [DATA_W-1:0] rdata0,
    output logic [DATA_W-1:0] rdata1,
    output logic              drop0,
    output logic              drop1,
    output logic [ADDR_W-1:0] address,
    output logic [DATA_W-1:0] wr_data,
    output logic              write_en,
    output logic              read_en,
    input  logic [DATA_W-1:0] rd_data
);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_CAPTURE, S_ACK} state_e;

    localparam logic [ADDR_W:0] ADDR_LIMIT = (ADDR_W + 1)'(NUM_REGS);

    function automatic logic is_legal(input logic [ADDR_W-1:0] a);
        return {1'b0, a} < ADDR_LIMIT;
    endfunction

    state_e                   state_q, state_d;
    logic                     grant_q, grant_d;
    logic                     last_grant_q, last_grant_d;
    logic [1:0]               slot_vld_q, slot_vld_d;
    logic [1:0]               slot_we_q, slot_we_d;
    logic [1:0][ADDR_W-1:0]   slot_addr_q, slot_addr_d;
    logic [1:0][DATA_W-1:0]   slot_wdata_q, slot_wdata_d;
    logic [1:0]               ack_q, ack_d;
    logic [1:0]               drop_q, drop_d;
    logic [1:0][DATA_W-1:0]   rdata_q, rdata_d;
    logic [ADDR_W-1:0]        address_q, address_d;
    logic [DATA_W-1:0]        wr_data_q, wr_data_d;
    logic                     write_en_q, write_en_d;
    logic                     read_en_q, read_en_d;

    logic [1:0]               strb_in, we_in;
    logic [1:0][ADDR_W-1:0]   addr_in;
    logic [1:0][DATA_W-1:0]   wdata_in;
    logic                     sel;

    assign strb_in  = {strb1, strb0};
    assign we_in    = {we1, we0};
    assign addr_in  = {addr1, addr0};
    assign wdata_in = {wdata1, wdata0};

    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        slot_vld_d   = slot_vld_q;
        slot_we_d    = slot_we_q;
        slot_addr_d  = slot_addr_q;
        slot_wdata_d = slot_wdata_q;
        ack_d        = '0;
        drop_d       = '0;
        rdata_d      = rdata_q;
        address_d    = address_q;
        wr_data_d    = wr_data_q;
        write_en_d   = 1'b0;
        read_en_d    = 1'b0;
        sel          = 1'b0;

        // A slot only loads when empty and only clears when full, so these never collide.
        for (int n = 0; n < 2; n++) begin
            if (strb_in[n]) begin
                if (slot_vld_q[n]) begin
                    drop_d[n] = 1'b1;
                end else begin
                    slot_vld_d[n]   = 1'b1;
                    slot_we_d[n]    = we_in[n];
                    slot_addr_d[n]  = addr_in[n];
                    slot_wdata_d[n] = wdata_in[n];
                end
            end
        end

        case (state_q)
            S_IDLE: begin
                if (|slot_vld_q) begin
                    sel          = (&slot_vld_q) ? ~last_grant_q : slot_vld_q[1];
                    grant_d      = sel;
                    last_grant_d = sel;
                    address_d    = slot_addr_q[sel];
                    wr_data_d    = slot_wdata_q[sel];
                    write_en_d   = slot_we_q[sel] & is_legal(slot_addr_q[sel]);
                    read_en_d    = ~slot_we_q[sel] & is_legal(slot_addr_q[sel]);
                    state_d      = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (slot_we_q[grant_q]) begin
                    ack_d[grant_q] = 1'b1;
                    state_d        = S_ACK;
                end else begin
                    state_d = S_CAPTURE;
                end
            end
            S_CAPTURE: begin
                rdata_d[grant_q] = is_legal(slot_addr_q[grant_q]) ? rd_data : '0;
                ack_d[grant_q]   = 1'b1;
                state_d          = S_ACK;
            end
            S_ACK: begin
                slot_vld_d[grant_q] = 1'b0;
                state_d             = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q      <= S_IDLE;
            grant_q      <= 1'b0;
            last_grant_q <= 1'b1;
            slot_vld_q   <= '0;
            slot_we_q    <= '0;
            slot_addr_q  <= '0;
            slot_wdata_q <= '0;
            ack_q        <= '0;
            drop_q       <= '0;
            rdata_q      <= '0;
            address_q    <= '0;
            wr_data_q    <= '0;
            write_en_q   <= 1'b0;
            read_en_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            slot_vld_q   <= slot_vld_d;
            slot_we_q    <= slot_we_d;
            slot_addr_q  <= slot_addr_d;
            slot_wdata_q <= slot_wdata_d;
            ack_q        <= ack_d;
            drop_q       <= drop_d;
            rdata_q      <= rdata_d;
            address_q    <= address_d;
            wr_data_q    <= wr_data_d;
            write_en_q   <= write_en_d;
            read_en_q    <= read_en_d;
        end
    end

    assign busy0    = slot_vld_q[0];
    assign busy1    = slot_vld_q[1];
    assign ack0     = ack_q[0];
    assign ack1     = ack_q[1];
    assign drop0    = drop_q[0];
    assign drop1    = drop_q[1];
    assign rdata0   = rdata_q[0];
    assign rdata1   = rdata_q[1];
    assign address  = address_q;
    assign wr_data  = wr_data_q;
    assign write_en = write_en_q;
    assign read_en  = read_en_q;

endmodule

// File: tb/tb_reg_bus_arbiter.sv
// Scoreboard bench for reg_bus_arbiter: a transaction-level schedule model predicts every event cycle.
module tb_reg_bus_arbiter;

    logic       clock = 1'b0;
    logic       reset_n = 1'b0;
    logic       strb0 = 1'b0, strb1 = 1'b0, we0 = 1'b0, we1 = 1'b0;
    logic [5:0] addr0 = '0, addr1 = '0;
    logic [7:0] wdata0 = '0, wdata1 = '0;
    logic       busy0, busy1, ack0, ack1, drop0, drop1, write_en, read_en;
    logic [7:0] rdata0, rdata1, wr_data;
    logic [7:0] rd_data = '0;
    logic [5:0] address;

    reg_bus_arbiter dut (
        .clock(clock), .reset_n(reset_n),
        .strb0(strb0), .strb1(strb1), .we0(we0), .we1(we1),
        .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
        .busy0(busy0), .busy1(busy1), .ack0(ack0), .ack1(ack1),
        .rdata0(rdata0), .rdata1(rdata1), .drop0(drop0), .drop1(drop1),
        .address(address), .wr_data(wr_data), .write_en(write_en), .read_en(read_en),
        .rd_data(rd_data)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    bit prev_rst_n = 1'b0;
    always @(posedge clock) begin
        cyc        <= cyc + 1;
        prev_rst_n <= reset_n;
    end

    // Register file environment: untouched locations return a fixed pattern.
    function automatic logic [7:0] init_val(input int i);
        if (i == 5) return 8'h3C;
        return 8'(i * 29 + 7);
    endfunction

    logic [7:0] mem [64];
    bit         mem_w [64];
    always @(posedge clock) begin
        if (write_en) begin
            mem[address]   <= wr_data;
            mem_w[address] <= 1'b1;
        end
        if (read_en) rd_data <= mem_w[address] ? mem[address] : init_val(int'(address));
    end

    typedef struct {int cyc; int req;} drop_ev_t;
    typedef struct {int cyc; int req; bit rd; logic [7:0] dat;} ack_ev_t;
    typedef struct {int cyc; bit we; logic [5:0] addr; logic [7:0] dat;} acc_ev_t;
    drop_ev_t drop_q[$];
    ack_ev_t  ack_q[$];
    acc_ev_t  acc_q[$];

    int checks = 0;
    int errors = 0;
    bit mon_en = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d got=%0h want=%0h", name, cyc, act, exp);
        end
    endtask

    // Reference model: one server; a grant happens in the first free cycle after a slot fills,
    // a write acks 2 cycles after its grant, a read 3; the next grant is possible the cycle after an ack.
    bit         m_pend [2];
    bit         m_sched [2];
    int         m_ack [2];
    bit         m_we [2];
    logic [5:0] m_addr [2];
    logic [7:0] m_wd [2];
    logic [7:0] m_mem [64];
    int         m_free = 0;
    int         m_last = 1;
    bit [1:0]   m_busy = '0;

    task automatic model_step(input int c, input bit rst, input bit [1:0] s, input bit [1:0] w,
                              input logic [5:0] a0, input logic [5:0] a1,
                              input logic [7:0] d0, input logic [7:0] d1);
        for (int n = 0; n < 2; n++)
            if (m_pend[n] && m_sched[n] && c > m_ack[n]) begin
                m_pend[n]  = 1'b0;
                m_sched[n] = 1'b0;
            end
        m_busy = {m_pend[1], m_pend[0]};
        if (rst) begin
            while (drop_q.size() > 0 && drop_q[$].cyc > c) void'(drop_q.pop_back());
            while (ack_q.size() > 0 && ack_q[$].cyc > c) void'(ack_q.pop_back());
            while (acc_q.size() > 0 && acc_q[$].cyc > c) void'(acc_q.pop_back());
            for (int n = 0; n < 2; n++) begin
                m_pend[n]  = 1'b0;
                m_sched[n] = 1'b0;
            end
            m_free = c + 1;
            m_last = 1;
            return;
        end
        if (c >= m_free && ((m_pend[0] && !m_sched[0]) || (m_pend[1] && !m_sched[1]))) begin
            int g;
            bit legal;
            logic [7:0] rdv;
            if (m_pend[0] && m_pend[1]) g = 1 - m_last;
            else g = m_pend[0] ? 0 : 1;
            legal = int'(m_addr[g]) < 36;
            if (legal) acc_q.push_back('{c + 1, m_we[g], m_addr[g], m_wd[g]});
            rdv = 8'h00;
            if (m_we[g]) begin
                if (legal) m_mem[m_addr[g]] = m_wd[g];
                m_ack[g] = c + 2;
            end else begin
                if (legal) rdv = m_mem[m_addr[g]];
                m_ack[g] = c + 3;
            end
            ack_q.push_back('{m_ack[g], g, !m_we[g], rdv});
            m_free     = m_ack[g] + 1;
            m_last     = g;
            m_sched[g] = 1'b1;
        end
        for (int n = 0; n < 2; n++)
            if (s[n]) begin
                if (m_busy[n]) drop_q.push_back('{c + 1, n});
                else begin
                    m_pend[n] = 1'b1;
                    m_we[n]   = w[n];
                    m_addr[n] = (n == 0) ? a0 : a1;
                    m_wd[n]   = (n == 0) ? d0 : d1;
                end
            end
    endtask

    task automatic drive(input bit rst,
                         input bit s0, input bit w0, input logic [5:0] a0, input logic [7:0] d0,
                         input bit s1, input bit w1, input logic [5:0] a1, input logic [7:0] d1);
        @(posedge clock);
        #1;
        reset_n = !rst;
        strb0 = s0 & !rst; we0 = w0; addr0 = a0; wdata0 = d0;
        strb1 = s1 & !rst; we1 = w1; addr1 = a1; wdata1 = d1;
        model_step(cyc, rst, {s1 & !rst, s0 & !rst}, {w1, w0}, a0, a1, d0, d1);
    endtask

    task automatic idle(input int n);
        repeat (n) drive(1'b0, 1'b0, 1'b0, 6'h0, 8'h0, 1'b0, 1'b0, 6'h0, 8'h0);
    endtask

    task automatic rst_cycles(input int n);
        repeat (n) drive(1'b1, 1'b0, 1'b0, 6'h0, 8'h0, 1'b0, 1'b0, 6'h0, 8'h0);
    endtask

    logic [7:0] exp_rdata [2];
    logic [1:0] dm, am;
    bit         acc_hit;
    acc_ev_t    acc_e;

    always @(negedge clock) begin
        if (mon_en) begin
            if (!prev_rst_n) begin
                chk("reset_outputs", 64'({busy1, busy0, ack1, ack0, drop1, drop0, rdata1, rdata0,
                                          address, wr_data, write_en, read_en}), 64'd0);
                exp_rdata[0] = 8'h00;
                exp_rdata[1] = 8'h00;
            end
            chk("busy", 64'({busy1, busy0}), 64'(m_busy));
            dm = '0;
            while (drop_q.size() > 0 && drop_q[0].cyc <= cyc) begin
                if (drop_q[0].cyc == cyc) dm[drop_q[0].req] = 1'b1;
                void'(drop_q.pop_front());
            end
            chk("drop", 64'({drop1, drop0}), 64'(dm));
            am = '0;
            while (ack_q.size() > 0 && ack_q[0].cyc <= cyc) begin
                if (ack_q[0].cyc == cyc) begin
                    am[ack_q[0].req] = 1'b1;
                    if (ack_q[0].rd) exp_rdata[ack_q[0].req] = ack_q[0].dat;
                end
                void'(ack_q.pop_front());
            end
            chk("ack", 64'({ack1, ack0}), 64'(am));
            chk("rdata0", 64'(rdata0), 64'(exp_rdata[0]));
            chk("rdata1", 64'(rdata1), 64'(exp_rdata[1]));
            acc_hit = 1'b0;
            while (acc_q.size() > 0 && acc_q[0].cyc <= cyc) begin
                if (acc_q[0].cyc == cyc) begin
                    acc_hit = 1'b1;
                    acc_e   = acc_q[0];
                end
                void'(acc_q.pop_front());
            end
            if (acc_hit) begin
                chk("wen_ren", 64'({write_en, read_en}), 64'({acc_e.we, !acc_e.we}));
                chk("address", 64'(address), 64'(acc_e.addr));
                if (acc_e.we) chk("wr_data", 64'(wr_data), 64'(acc_e.dat));
            end else begin
                chk("wen_ren_idle", 64'({write_en, read_en}), 64'd0);
            end
        end
    end

    initial begin
        for (int i = 0; i < 64; i++) m_mem[i] = init_val(i);
        exp_rdata[0] = 8'h00;
        exp_rdata[1] = 8'h00;
        rst_cycles(3);
        idle(1);
        mon_en = 1'b1;

        // Single write, then a read held through later requester-0 traffic.
        drive(1'b0, 1'b1, 1'b1, 6'h04, 8'hA5, 1'b0, 1'b0, 6'h00, 8'h00);
        idle(6);
        chk("mem4", 64'(mem[4]), 64'h00000000000000A5);
        drive(1'b0, 1'b0, 1'b0, 6'h00, 8'h00, 1'b1, 1'b0, 6'h05, 8'h00);
        idle(6);
        drive(1'b0, 1'b1, 1'b1, 6'h06, 8'h5A, 1'b0, 1'b0, 6'h00, 8'h00);
        idle(6);
        chk("rdata1_held", 64'(rdata1), 64'h000000000000003C);

        // Same-cycle strobes twice after reset: requester 0 wins both rounds.
        rst_cycles(2);
        drive(1'b0, 1'b1, 1'b1, 6'h0C, 8'h11, 1'b1, 1'b1, 6'h0E, 8'h22);
        idle(8);
        drive(1'b0, 1'b1, 1'b1, 6'h0C, 8'h33, 1'b1, 1'b1, 6'h0E, 8'h44);
        idle(8);

        // Illegal write and illegal read.
        drive(1'b0, 1'b1, 1'b1, 6'h24, 8'hEE, 1'b0, 1'b0, 6'h00, 8'h00);
        idle(5);
        drive(1'b0, 1'b1, 1'b0, 6'h3F, 8'h00, 1'b0, 1'b0, 6'h00, 8'h00);
        idle(6);

        // Overflow: strobe while busy and strobe in the ack cycle.
        drive(1'b0, 1'b1, 1'b1, 6'h10, 8'h77, 1'b0, 1'b0, 6'h00, 8'h00);
        drive(1'b0, 1'b1, 1'b1, 6'h11, 8'h88, 1'b0, 1'b0, 6'h00, 8'h00);
        idle(1);
        drive(1'b0, 1'b1, 1'b1, 6'h12, 8'h99, 1'b0, 1'b0, 6'h00, 8'h00);
        idle(5);
        chk("mem16", 64'(mem[16]), 64'h0000000000000077);

        // Reset in the CAPTURE cycle of a read, then a normal write.
        drive(1'b0, 1'b0, 1'b0, 6'h00, 8'h00, 1'b1, 1'b0, 6'h04, 8'h00);
        idle(2);
        rst_cycles(1);
        drive(1'b0, 1'b1, 1'b1, 6'h07, 8'hC3, 1'b0, 1'b0, 6'h00, 8'h00);
        idle(6);

        // Randomized traffic with occasional resets.
        for (int k = 0; k < 1500; k++) begin
            bit r, s0, s1, w0, w1;
            logic [5:0] a0, a1;
            r  = ($urandom_range(0, 299) == 0);
            s0 = ($urandom_range(0, 2) == 0);
            s1 = ($urandom_range(0, 2) == 0);
            w0 = $urandom_range(0, 1) == 1;
            w1 = $urandom_range(0, 1) == 1;
            a0 = ($urandom_range(0, 3) == 0) ? 6'($urandom_range(36, 63)) : 6'($urandom_range(0, 35));
            a1 = ($urandom_range(0, 3) == 0) ? 6'($urandom_range(36, 63)) : 6'($urandom_range(0, 35));
            drive(r, s0, w0, a0, 8'($urandom), s1, w1, a1, 8'($urandom));
        end
        idle(12);

        chk("drain_ack", 64'(ack_q.size()), 64'd0);
        chk("drain_drop", 64'(drop_q.size()), 64'd0);
        chk("drain_acc", 64'(acc_q.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
